connect4_turn_controller: RTL and testbench
===========================================

Name: connect4_turn_controller

Overview:
- Sequences one game turn of the Connect-4 datapath.
- Accepts a confirmed column from the player-input block and finds the lowest free row from internal per-column height counters.
- Optionally animates the falling piece, writes the cell to the board memory, then runs the external win checker through a start/done handshake.
- Alternates players, and declares a win or a draw.

Parameters:
- NUM_COLS, 7, number of board columns (column index 0..NUM_COLS-1).
- NUM_ROWS, 6, number of board rows (row 0 = bottom).
- DROP_TICKS, 4, clock cycles the falling piece spends on each row during the drop animation (must be >=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- move_valid  input  1  confirmed-move request from the input block
- move_col  input  3  requested column
- move_ready  output  1  controller can accept a move this cycle
- illegal_move  output  1  one-cycle pulse: rejected move
- board_we  output  1  one-cycle board-cell write strobe
- board_row  output  3  row being written
- board_col  output  3  column being written
- board_player  output  1  piece owner written (0 = P1, 1 = P2)
- anim_active  output  1  falling-piece animation in progress
- anim_row  output  3  current row of the falling piece
- chk_start  output  1  one-cycle pulse starting the win checker
- chk_done  input  1  win checker finished
- chk_win  input  1  last move wins; sampled only when chk_done=1
- cur_player  output  1  player to move
- game_over  output  1  game ended
- winner  output  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset state:
  - State WAIT_MOVE; all heights 0; move_count 0; cur_player 0.
  - winner 00, game_over 0; all strobes 0; anim_active 0; anim_row 0; board_row/col 0; move_ready 1.
- WAIT_MOVE:
  - move_ready=1. A move is accepted on the cycle with move_valid & move_ready.
  - Illegal if move_col>=NUM_COLS or height[move_col]==NUM_ROWS. Then illegal_move pulses on the next cycle, state is unchanged, and no write occurs.
  - Legal: latch col and target=height[col], then enter DROP. move_ready=0 in every state except WAIT_MOVE.
- DROP:
  - On entry anim_row=NUM_ROWS-1 and anim_active=1.
  - If anim_row==target, go to WRITE on the next cycle.
  - Otherwise hold DROP_TICKS cycles, then decrement anim_row.
  - Accepted-to-board_we latency = 2 + (NUM_ROWS-1-target)*DROP_TICKS cycles.
- WRITE:
  - board_we=1 for exactly one cycle, with board_row=target, board_col=col, board_player=cur_player.
  - height[col]++ and move_count++. anim_active drops to 0. Go to CHECK.
- CHECK:
  - chk_start pulses on the first CHECK cycle only, then the controller waits for chk_done; hold indefinitely.
  - On chk_done & chk_win: winner = cur_player ? 10 : 01, go to OVER.
  - Else if move_count==NUM_ROWS*NUM_COLS: winner 11, go to OVER.
  - Else toggle cur_player and return to WAIT_MOVE.
- OVER:
  - game_over=1; all requests ignored.
  - Stays in OVER until reset; move_valid here never pulses illegal_move.
- Counter widths: height holds 0..NUM_ROWS; move_count holds 0..NUM_ROWS*NUM_COLS. No wrap: a full column is always rejected.
- move_valid held high across cycles is accepted only once per WAIT_MOVE visit.
- Reset mid-turn (DROP, WRITE or CHECK) aborts immediately. No board_we is issued after reset is sampled; the board memory is cleared elsewhere.

Optional Feature:
- Macro: DROP_ANIM_EN.
- Defined: DROP behaves as above.
- Undefined: DROP state removed; a legal accept goes straight to WRITE, so board_we asserts 1 cycle after accept. anim_active is tied 0 and anim_row tied 0.

Test Plan:
1. Reset, then move col 3 with DROP_TICKS=4 and the animation macro defined -> anim_row steps 5,4,3,2,1,0; board_we at cycle 2+5*4=22 with row 0, col 3, player 0; chk_start pulse; chk_done=1, chk_win=0 -> cur_player=1, move_ready=1.
2. Six legal moves into col 2, then a seventh into col 2 -> seventh gives illegal_move pulse, no board_we, cur_player unchanged.
3. move_col=7 -> illegal_move pulse, state stays WAIT_MOVE.
4. P2 move answered with chk_done=1, chk_win=1 -> winner=10, game_over=1; later move_valid ignored with no strobes.
5. 42 legal moves with chk_win=0 throughout -> after the 42nd check, winner=11 and game_over=1.
6. Reset asserted during DROP (and again during CHECK) -> next cycle in WAIT_MOVE, no board_we issued, heights 0, cur_player 0.

Source files
------------

// File: rtl/connect4_turn_controller.sv
// Connect-4 turn sequencer: accept column, find landing row, (optionally) animate the drop,
// write the board cell, run the win checker, then alternate players or end the game. Option: DROP_ANIM_EN.
module connect4_turn_controller #(
  parameter int unsigned NUM_COLS   = 7,
  parameter int unsigned NUM_ROWS   = 6,
  parameter int unsigned DROP_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  output logic       illegal_move,
  output logic       board_we,
  output logic [2:0] board_row,
  output logic [2:0] board_col,
  output logic       board_player,
  output logic       anim_active,
  output logic [2:0] anim_row,
  output logic       chk_start,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic       cur_player,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned HW = $clog2(NUM_ROWS + 1);
  localparam int unsigned MW = $clog2(NUM_ROWS * NUM_COLS + 1);
  localparam int unsigned TW = $clog2(DROP_TICKS + 1);

  typedef enum logic [2:0] {WAIT_MOVE, DROP, WRITE, CHECK, OVER} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] height_q [NUM_COLS];
  logic [HW-1:0] height_d [NUM_COLS];
  logic [MW-1:0] move_count_q, move_count_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    col_q, col_d, target_q, target_d;
  logic [2:0]    anim_row_q, anim_row_d, board_row_q, board_row_d, board_col_q, board_col_d;
  logic          anim_active_q, anim_active_d, taken_q, taken_d;
  logic          cur_player_q, cur_player_d, board_player_q, board_player_d;
  logic          move_ready_q, move_ready_d, illegal_q, illegal_d, we_q, we_d;
  logic          chk_start_q, chk_start_d, game_over_q, game_over_d;
  logic [1:0]    winner_q, winner_d;
  logic          col_ok;
  logic [2:0]    sel;

  assign col_ok = 32'(move_col) < NUM_COLS;
  assign sel    = col_ok ? move_col : 3'd0;

  // Next-state and output computation
  always_comb begin
    state_d        = state_q;
    height_d       = height_q;
    move_count_d   = move_count_q;
    tick_d         = tick_q;
    col_d          = col_q;
    target_d       = target_q;
    anim_row_d     = anim_row_q;
    anim_active_d  = anim_active_q;
    taken_d        = taken_q;
    cur_player_d   = cur_player_q;
    board_row_d    = board_row_q;
    board_col_d    = board_col_q;
    board_player_d = board_player_q;
    winner_d       = winner_q;
    illegal_d      = 1'b0;
    we_d           = 1'b0;
    chk_start_d    = 1'b0;
    case (state_q)
      WAIT_MOVE: begin
        // taken_q blocks a held move_valid from being accepted twice in one visit
        if (!move_valid) begin
          taken_d = 1'b0;
        end else if (!taken_q) begin
          taken_d = 1'b1;
          if (!col_ok || height_q[sel] == HW'(NUM_ROWS)) begin
            illegal_d = 1'b1;
          end else begin
            taken_d  = 1'b0;
            col_d    = move_col;
            target_d = 3'(height_q[sel]);
`ifdef DROP_ANIM_EN
            state_d       = DROP;
            anim_row_d    = 3'(NUM_ROWS - 1);
            anim_active_d = 1'b1;
            tick_d        = '0;
`else
            state_d = WRITE;
`endif
          end
        end
      end
`ifdef DROP_ANIM_EN
      DROP: begin
        if (anim_row_q == target_q) begin
          state_d = WRITE;
        end else if (tick_q == TW'(DROP_TICKS - 1)) begin
          tick_d     = '0;
          anim_row_d = anim_row_q - 3'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`endif
      WRITE: begin
        we_d              = 1'b1;
        chk_start_d       = 1'b1;
        board_row_d       = target_q;
        board_col_d       = col_q;
        board_player_d    = cur_player_q;
        height_d[col_q]   = height_q[col_q] + HW'(1);
        move_count_d      = move_count_q + MW'(1);
        anim_active_d     = 1'b0;
        state_d           = CHECK;
      end
      CHECK: begin
        if (chk_done) begin
          if (chk_win) begin
            winner_d = cur_player_q ? 2'b10 : 2'b01;
            state_d  = OVER;
          end else if (move_count_q == MW'(NUM_ROWS * NUM_COLS)) begin
            winner_d = 2'b11;
            state_d  = OVER;
          end else begin
            cur_player_d = ~cur_player_q;
            state_d      = WAIT_MOVE;
          end
        end
      end
      default: ;
    endcase
    move_ready_d = (state_d == WAIT_MOVE) && !taken_d;
    game_over_d  = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WAIT_MOVE;
      for (int i = 0; i < int'(NUM_COLS); i++) height_q[i] <= '0;
      move_count_q   <= '0;
      tick_q         <= '0;
      col_q          <= '0;
      target_q       <= '0;
      anim_row_q     <= '0;
      anim_active_q  <= 1'b0;
      taken_q        <= 1'b0;
      cur_player_q   <= 1'b0;
      board_row_q    <= '0;
      board_col_q    <= '0;
      board_player_q <= 1'b0;
      winner_q       <= 2'b00;
      illegal_q      <= 1'b0;
      we_q           <= 1'b0;
      chk_start_q    <= 1'b0;
      move_ready_q   <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      height_q       <= height_d;
      move_count_q   <= move_count_d;
      tick_q         <= tick_d;
      col_q          <= col_d;
      target_q       <= target_d;
      anim_row_q     <= anim_row_d;
      anim_active_q  <= anim_active_d;
      taken_q        <= taken_d;
      cur_player_q   <= cur_player_d;
      board_row_q    <= board_row_d;
      board_col_q    <= board_col_d;
      board_player_q <= board_player_d;
      winner_q       <= winner_d;
      illegal_q      <= illegal_d;
      we_q           <= we_d;
      chk_start_q    <= chk_start_d;
      move_ready_q   <= move_ready_d;
      game_over_q    <= game_over_d;
    end
  end

  assign move_ready   = move_ready_q;
  assign illegal_move = illegal_q;
  assign board_we     = we_q;
  assign board_row    = board_row_q;
  assign board_col    = board_col_q;
  assign board_player = board_player_q;
  assign chk_start    = chk_start_q;
  assign cur_player   = cur_player_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;
`ifdef DROP_ANIM_EN
  assign anim_active  = anim_active_q;
  assign anim_row     = anim_row_q;
`else
  assign anim_active  = 1'b0;
  assign anim_row     = 3'd0;
`endif

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Directed bench for connect4_turn_controller: move table, full-board draw, held requests, mid-turn resets.
module tb_connect4_turn_controller;

  localparam int NUM_ROWS   = 6;
  localparam int DROP_TICKS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic       chk_done = 1'b0;
  logic       chk_win = 1'b0;
  logic       move_ready, illegal_move, board_we, board_player, anim_active;
  logic       chk_start, cur_player, game_over;
  logic [2:0] board_row, board_col, anim_row;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  connect4_turn_controller dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .illegal_move(illegal_move), .board_we(board_we),
    .board_row(board_row), .board_col(board_col), .board_player(board_player),
    .anim_active(anim_active), .anim_row(anim_row), .chk_start(chk_start),
    .chk_done(chk_done), .chk_win(chk_win), .cur_player(cur_player),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] col;
    logic       win;
    logic       ill;
    logic [2:0] row;
    logic       pl;
    logic       cp;
    logic [1:0] wcode;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input int row);
`ifdef DROP_ANIM_EN
    return 2 + (NUM_ROWS - 1 - row) * DROP_TICKS;
`else
    return 1;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_move_ready", 32'(move_ready), 1);
    check("rst_cur_player", 32'(cur_player), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_winner", 32'(winner), 0);
    check("rst_strobes", {29'd0, board_we, illegal_move, chk_start}, 0);
    check("rst_anim", {28'd0, anim_active, anim_row}, 0);
    check("rst_board_pos", {26'd0, board_row, board_col}, 0);
    reset = 1'b0;
  endtask

  task automatic do_move(input vec_t v, input string tag);
    int n;
    move_col   = v.col;
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    check({tag, "_illegal"}, 32'(illegal_move), 32'(v.ill));
    if (v.ill) begin
      step();
      check({tag, "_ill_pulse_end"}, 32'(illegal_move), 0);
      check({tag, "_ill_no_we"}, 32'(board_we), 0);
      check({tag, "_ill_ready"}, 32'(move_ready), 1);
      check({tag, "_ill_cp"}, 32'(cur_player), 32'(v.cp));
    end else begin
`ifdef DROP_ANIM_EN
      check({tag, "_anim_start"}, {28'd0, anim_active, anim_row}, {28'd0, 1'b1, 3'd5});
`else
      check({tag, "_anim_tied"}, {28'd0, anim_active, anim_row}, 0);
`endif
      n = 0;
      while (board_we !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(exp_lat(int'(v.row))));
      check({tag, "_row"}, 32'(board_row), 32'(v.row));
      check({tag, "_col"}, 32'(board_col), 32'(v.col));
      check({tag, "_player"}, 32'(board_player), 32'(v.pl));
      check({tag, "_chk_start"}, 32'(chk_start), 1);
      step();
      check({tag, "_pulses_end"}, {30'd0, board_we, chk_start}, 0);
      chk_done = 1'b1;
      chk_win  = v.win;
      step();
      chk_done = 1'b0;
      chk_win  = 1'b0;
      check({tag, "_cp_after"}, 32'(cur_player), 32'(v.cp));
      check({tag, "_winner"}, 32'(winner), 32'(v.wcode));
      check({tag, "_game_over"}, 32'(game_over), 32'(v.wcode != 2'b00));
      check({tag, "_ready_after"}, 32'(move_ready), 32'(v.wcode == 2'b00));
    end
  endtask

  initial begin
    vec_t v;
    int   cnt;
    int   n;

    // col, win, illegal, row, written player, cur_player after, winner after
    tbl[0] = '{3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00};
    for (int i = 1; i <= 6; i++)
      tbl[i] = '{3'd2, 1'b0, 1'b0, 3'(i - 1), 1'((i % 2) == 1), 1'((i % 2) == 0), 2'b00};
    tbl[7] = '{3'd2, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'b00};
    tbl[8] = '{3'd7, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'b00};
    tbl[9] = '{3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 2'b10};

    do_reset();
    for (int i = 0; i < 10; i++) do_move(tbl[i], $sformatf("tbl%0d", i));

    // Game over: requests ignored, no strobes
    cnt = 0;
    move_col   = 3'd4;
    move_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(illegal_move) + int'(board_we) + int'(chk_start);
    end
    move_valid = 1'b0;
    check("over_no_strobes", 32'(cnt), 0);
    check("over_hold", {29'd0, game_over, winner}, {29'd0, 1'b1, 2'b10});
    check("over_not_ready", 32'(move_ready), 0);

    // Held illegal request pulses illegal_move only once
    do_reset();
    cnt = 0;
    move_col   = 3'd7;
    move_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(illegal_move);
    end
    move_valid = 1'b0;
    check("held_illegal_once", 32'(cnt), 1);
    step();
    check("held_release_ready", 32'(move_ready), 1);

    // Full board without a win ends in a draw
    do_reset();
    for (int i = 0; i < 42; i++) begin
      v = '{3'(i / 6), 1'b0, 1'b0, 3'(i % 6), 1'(i % 2),
            (i == 41) ? 1'b1 : 1'((i + 1) % 2), (i == 41) ? 2'b11 : 2'b00};
      do_move(v, $sformatf("draw%0d", i));
    end

    // Reset right after accept (DROP, or WRITE without animation)
    do_reset();
    do_move(tbl[0], "pre_abort");
    move_col   = 3'd5;
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = int'(board_we);
    for (int i = 0; i < 30; i++) begin
      step();
      cnt += int'(board_we);
    end
    check("abort_drop_no_we", 32'(cnt), 0);
    check("abort_drop_cp", 32'(cur_player), 0);
    check("abort_drop_ready", 32'(move_ready), 1);
    v = '{3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00};
    do_move(v, "post_abort_drop");

    // Reset while waiting in CHECK
    move_col   = 3'd3;
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    n = 0;
    while (board_we !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("chk_abort_we_seen", 32'(board_we), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(board_we) + int'(chk_start);
    end
    check("abort_chk_no_strobe", 32'(cnt), 0);
    check("abort_chk_cp", 32'(cur_player), 0);
    v = '{3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00};
    do_move(v, "post_abort_chk");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
